// File: rtl/mem_pkg.sv
// mem_pkg: shared state encoding and opcodes for the data-memory responder.
package mem_pkg;
    typedef enum logic [1:0] {IDLE, BUSY, RESP} state_t;
    localparam logic [5:0] OP_LW = 6'b010001;
    localparam logic [5:0] OP_SW = 6'b010000;
endpackage

// File: rtl/data_ram.sv
// data_ram: single-port synchronous word RAM; read-during-write returns old data.
module data_ram #(
    parameter int DEPTH = 256
) (
    input  logic                     clk,
    input  logic                     we,
    input  logic [$clog2(DEPTH)-1:0] idx,
    input  logic [31:0]              wdata,
    output logic [31:0]              rdata
);
    logic [31:0] mem [DEPTH];

    always_ff @(posedge clk) begin
        if (we) mem[idx] <= wdata;
        rdata <= mem[idx];
    end
endmodule

// File: rtl/data_mem_responder.sv
// data_mem_responder: multi-cycle load/store responder with fixed latency,
// pipeline stall and one-cycle Done/Error completion pulses.
module data_mem_responder
    import mem_pkg::*;
#(
    parameter int DEPTH   = 256,
    parameter int LATENCY = 2
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        MemRead,
    input  logic        MemWrite,
    input  logic [31:0] Addr,
    input  logic [31:0] WriteData,
    output logic [31:0] ReadData,
    output logic        Stall,
    output logic        Done,
    output logic        Error
);
    localparam int AW = $clog2(DEPTH);
    localparam int CW = $clog2(LATENCY + 1);

    state_t          state_q, state_d;
    logic [CW-1:0]   cnt_q, cnt_d;
    logic [AW-1:0]   idx_q, idx_d;
    logic [31:0]     wdata_q, wdata_d;
    logic            wr_q, wr_d;
    logic            bad_q, bad_d;
    logic [31:0]     rdata_q, rdata_d;
    logic            we;
    logic            req;
    logic [AW-1:0]   ram_idx;
    logic [31:0]     ram_rdata;

    assign req = MemRead | MemWrite;
    // RAM is addressed from the live request in IDLE so the read word is ready during BUSY
    assign ram_idx = (state_q == IDLE) ? Addr[AW+1:2] : idx_q;

    data_ram #(.DEPTH(DEPTH)) u_ram (
        .clk   (clk),
        .we    (we & rst_n),
        .idx   (ram_idx),
        .wdata (wdata_q),
        .rdata (ram_rdata)
    );

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        idx_d   = idx_q;
        wdata_d = wdata_q;
        wr_d    = wr_q;
        bad_d   = bad_q;
        rdata_d = rdata_q;
        we      = 1'b0;
        case (state_q)
            IDLE: if (req) begin
                state_d = BUSY;
                cnt_d   = CW'(LATENCY - 1);
                idx_d   = Addr[AW+1:2];
                wdata_d = WriteData;
                wr_d    = MemWrite;
                bad_d   = (Addr[1:0] != 2'b00) | (MemRead & MemWrite);
            end
            BUSY: if (cnt_q != '0) begin
                cnt_d = cnt_q - CW'(1);
            end else begin
                state_d = RESP;
                we      = wr_q & ~bad_q;
                if (bad_q || !wr_q) rdata_d = bad_q ? 32'd0 : ram_rdata;
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q <= IDLE;
            cnt_q   <= '0;
            idx_q   <= '0;
            wdata_q <= '0;
            wr_q    <= 1'b0;
            bad_q   <= 1'b0;
            rdata_q <= '0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            idx_q   <= idx_d;
            wdata_q <= wdata_d;
            wr_q    <= wr_d;
            bad_q   <= bad_d;
            rdata_q <= rdata_d;
        end
    end

    assign ReadData = rdata_q;
    assign Stall    = ((state_q == IDLE) & req) | (state_q == BUSY);
    assign Done     = (state_q == RESP);
    assign Error    = (state_q == RESP) & bad_q;
endmodule

// File: tb/tb_data_mem_responder.sv
// tb_data_mem_responder: table-driven directed vectors plus reset-abort and back-to-back sequences.
module tb_data_mem_responder;
    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        MemRead = 1'b0;
    logic        MemWrite = 1'b0;
    logic [31:0] Addr = '0;
    logic [31:0] WriteData = '0;
    logic [31:0] ReadData;
    logic        Stall, Done, Error;

    int n_vec = 0;
    int n_bad = 0;
    int cyc = 0;
    int done_cnt = 0;

    data_mem_responder #(.DEPTH(256), .LATENCY(2)) dut (
        .clk(clk), .rst_n(rst_n), .MemRead(MemRead), .MemWrite(MemWrite),
        .Addr(Addr), .WriteData(WriteData), .ReadData(ReadData),
        .Stall(Stall), .Done(Done), .Error(Error)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;
    always @(negedge clk) if (Done) done_cnt <= done_cnt + 1;

    typedef struct {
        logic        rd;
        logic        wr;
        logic [31:0] addr;
        logic [31:0] wdata;
        logic [31:0] exp_rd;
        logic        exp_err;
    } vec_t;

    vec_t vecs [11];

    task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got %h, expected %h", name, got, exp);
        end
    endtask

    task automatic run(input logic rd, input logic wr, input logic [31:0] a, input logic [31:0] wd,
                       output logic [31:0] rdata, output logic err, output int stalls,
                       output bit seen, output int done_at);
        MemRead = rd; MemWrite = wr; Addr = a; WriteData = wd;
        #1;
        stalls = 0; seen = 0; rdata = 'x; err = 1'bx; done_at = -1;
        for (int i = 0; i < 20 && !seen; i++) begin
            if (Stall) stalls++;
            if (Done) begin
                seen = 1; rdata = ReadData; err = Error; done_at = cyc;
            end
            @(negedge clk); #1;
        end
        MemRead = 0; MemWrite = 0;
        if (!seen) begin
            n_vec++; n_bad++;
            $display("FAIL timeout: no Done for addr %h", a);
        end
    endtask

    logic [31:0] rdata;
    logic        err;
    int          stalls, d0, d1, d2, dc;
    bit          seen;

    initial begin
        vecs[0]  = '{1'b0, 1'b1, 32'h10,  32'hDEADBEEF, 32'h0,        1'b0};
        vecs[1]  = '{1'b1, 1'b0, 32'h10,  32'h0,        32'hDEADBEEF, 1'b0};
        vecs[2]  = '{1'b0, 1'b1, 32'h20,  32'hAAAA5555, 32'hDEADBEEF, 1'b0};
        vecs[3]  = '{1'b1, 1'b0, 32'h13,  32'h0,        32'h0,        1'b1};
        vecs[4]  = '{1'b1, 1'b1, 32'h10,  32'h11111111, 32'h0,        1'b1};
        vecs[5]  = '{1'b1, 1'b0, 32'h10,  32'h0,        32'hDEADBEEF, 1'b0};
        vecs[6]  = '{1'b0, 1'b1, 32'h400, 32'h12345678, 32'hDEADBEEF, 1'b0};
        vecs[7]  = '{1'b1, 1'b0, 32'h0,   32'h0,        32'h12345678, 1'b0};
        vecs[8]  = '{1'b0, 1'b1, 32'h11,  32'h0BADF00D, 32'h0,        1'b1};
        vecs[9]  = '{1'b1, 1'b0, 32'h10,  32'h0,        32'hDEADBEEF, 1'b0};
        vecs[10] = '{1'b1, 1'b0, 32'h420, 32'h0,        32'hAAAA5555, 1'b0};

        repeat (3) @(negedge clk);
        #1;
        chk("reset Stall", {31'd0, Stall}, 32'd0);
        chk("reset Done", {31'd0, Done}, 32'd0);
        chk("reset Error", {31'd0, Error}, 32'd0);
        chk("reset ReadData", ReadData, 32'd0);
        rst_n = 1'b1;
        @(negedge clk); #1;
        chk("idle Stall", {31'd0, Stall}, 32'd0);

        for (int i = 0; i < 11; i++) begin
            run(vecs[i].rd, vecs[i].wr, vecs[i].addr, vecs[i].wdata, rdata, err, stalls, seen, d0);
            if (seen) begin
                chk($sformatf("v%0d ReadData", i), rdata, vecs[i].exp_rd);
                chk($sformatf("v%0d Error", i), {31'd0, err}, {31'd0, vecs[i].exp_err});
                chk($sformatf("v%0d stall cycles", i), stalls, 32'd3);
            end
        end

        // reset asserted in the final BUSY cycle of a store to 0x20
        dc = done_cnt;
        MemWrite = 1; Addr = 32'h20; WriteData = 32'hFFFFFFFF;
        @(negedge clk); #1;
        @(negedge clk); #1;
        chk("abort in BUSY Stall", {31'd0, Stall}, 32'd1);
        rst_n = 0; MemWrite = 0;
        @(negedge clk); #1;
        chk("abort Stall", {31'd0, Stall}, 32'd0);
        chk("abort Done", {31'd0, Done}, 32'd0);
        chk("abort ReadData", ReadData, 32'd0);
        @(negedge clk); #1;
        rst_n = 1;
        @(negedge clk); #1;
        chk("abort no Done pulse", done_cnt - dc, 32'd0);
        run(1, 0, 32'h20, 0, rdata, err, stalls, seen, d0);
        if (seen) chk("abort load 0x20", rdata, 32'hAAAA5555);

        // back-to-back load/store/load
        dc = done_cnt;
        run(1, 0, 32'h10, 0, rdata, err, stalls, seen, d0);
        if (seen) chk("b2b load1", rdata, 32'hDEADBEEF);
        run(0, 1, 32'h30, 32'hCAFEF00D, rdata, err, stalls, seen, d1);
        if (seen) chk("b2b store holds", rdata, 32'hDEADBEEF);
        run(1, 0, 32'h30, 0, rdata, err, stalls, seen, d2);
        if (seen) chk("b2b load2", rdata, 32'hCAFEF00D);
        chk("b2b spacing 1", d1 - d0, 32'd4);
        chk("b2b spacing 2", d2 - d1, 32'd4);
        repeat (3) @(negedge clk);
        chk("b2b Done count", done_cnt - dc, 32'd3);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end
endmodule
